vga_timing_gen: RTL
===================

// Module: vga_timing_gen
// PURPOSE
// - Parametrised raster timing generator; successor to the fixed 640x480 VGA controller.
// - Produces Hsync/Vsync, the active-video flag and pixel coordinates for any mode from porch/sync params.
// - Single clock domain; vertical counter advances on the same clock edge as horizontal wrap.
//   No derived clock.
// - Feeds the pixel/sprite renderers and the frame-buffer read logic.
// PARAMETERS
// - H_ACTIVE 640 : visible pixels per line
// - H_FP 16 : horizontal front porch, pixels
// - H_SYNC 96 : horizontal sync width, pixels
// - H_BP 48 : horizontal back porch, pixels
// - V_ACTIVE 480 : visible lines per frame
// - V_FP 10 : vertical front porch, lines
// - V_SYNC 2 : vertical sync width, lines
// - V_BP 33 : vertical back porch, lines
// - HSYNC_POL 0 : sync active level, 0 = active-low
// - VSYNC_POL 0 : sync active level, 0 = active-low
// - CW 10 : counter width; must hold H_TOTAL-1 and V_TOTAL-1
// PORTS
// - PixelClock  in  1   pixel/system clock, rising edge
// - Reset       in  1   asynchronous, active-high
// - PixelEnable in  1   clock enable; counters advance only on enabled edges
// - Hsync       out 1   horizontal sync, level per HSYNC_POL
// - Vsync       out 1   vertical sync, level per VSYNC_POL
// - displayON   out 1   high while Xpixel<H_ACTIVE and Ypixel<V_ACTIVE
// - Xpixel      out CW  current column, 0..H_TOTAL-1
// - Ypixel      out CW  current line, 0..V_TOTAL-1
// - LineStart   out 1   one-cycle pulse when Xpixel becomes 0
// - FrameStart  out 1   one-cycle pulse when (Xpixel,Ypixel) becomes (0,0)
// BEHAVIOUR
// - Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Defaults give 800 x 525.
// - Reset values: Xpixel=H_TOTAL-1, Ypixel=V_TOTAL-1, displayON=0, Hsync=Vsync=inactive,
//   LineStart=FrameStart=0.
//   The first enabled edge after reset yields (0,0) with LineStart=FrameStart=1.
// - Enabled edge, X counter: Xpixel==H_TOTAL-1 -> 0, otherwise +1.
// - Enabled edge, Y counter: Ypixel changes only on that X wrap.
//   Ypixel==V_TOTAL-1 -> 0, otherwise +1.
// - Sync windows:
//   - Hsync active for Xpixel in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] (defaults 656..751).
//   - Vsync active for Ypixel in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] (defaults 490..491).
// - Hsync, Vsync, displayON, LineStart and FrameStart are registered.
//   Each is decoded from the next-state counter values, so it is aligned with Xpixel/Ypixel in
//   the same cycle: zero skew, zero latency.
// - PixelEnable low: all counters and level outputs hold.
//   LineStart/FrameStart clear on the next clock edge regardless of enable. A pulse is never
//   stretched by a stall.
// - Reset mid-frame: immediately returns to the reset values; timing restarts with a clean
//   frame. No partial sync pulse beyond reset assertion.
// - Counter arithmetic is CW bits. The parameter set is legal only if H_TOTAL and V_TOTAL
//   are <= 2**CW; out-of-range sets are a configuration error.
// CONFIGURATION
// - Macro VGA_FRAME_COUNT_EN:
//   - Defined: adds output FrameCount (8 bits, reset 0).
//     FrameCount increments on every enabled edge that loads (0,0) and wraps 255 -> 0.
//     It updates in the same cycle FrameStart rises.
//   - Undefined: port and logic absent; all other behaviour identical.
// TESTING
// - Reset release, PixelEnable=1 -> first edge: X=0, Y=0, displayON=1, FrameStart=1, LineStart=1.
//   Next edge: both pulses 0.
// - One line, defaults -> Xpixel wraps 799 -> 0 after 800 cycles.
//   Hsync low exactly cycles X=656..751; displayON low for X=640..799.
// - One frame, defaults -> 420000 cycles between FrameStart pulses.
//   Vsync low exactly lines 490..491 (1600 cycles); Ypixel wraps 524 -> 0.
// - PixelEnable toggling 1/0 -> line takes 1600 clocks; outputs hold on disabled cycles.
//   LineStart is high exactly one clock per line.
// - Reset asserted at X=300, Y=200 -> outputs return to reset values asynchronously.
//   Release gives FrameStart on the first enabled edge.
// - HSYNC_POL=1, VSYNC_POL=1, 800x600 params -> syncs high-active in correct windows.
//   With VGA_FRAME_COUNT_EN, 256 frames -> FrameCount wraps to 0.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: sync, active-video flag, pixel coordinates and line/frame pulses.
// Optional macro VGA_FRAME_COUNT_EN adds an 8-bit FrameCount output.
module vga_timing_gen #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int HSYNC_POL = 0,
    parameter int VSYNC_POL = 0,
    parameter int CW        = 10
) (
    input  logic          PixelClock,
    input  logic          Reset,
    input  logic          PixelEnable,
    output logic          Hsync,
    output logic          Vsync,
    output logic          displayON,
    output logic [CW-1:0] Xpixel,
    output logic [CW-1:0] Ypixel,
    output logic          LineStart,
`ifdef VGA_FRAME_COUNT_EN
    output logic          FrameStart,
    output logic [7:0]    FrameCount
`else
    output logic          FrameStart
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Totals must fit in CW bits (H_TOTAL, V_TOTAL <= 2**CW); larger sets are a configuration error.
    localparam logic [CW-1:0] H_MAX      = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_MAX      = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT      = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT      = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_FIRST   = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_LAST    = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CW-1:0] VS_FIRST   = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_LAST    = CW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [CW-1:0] ONE        = {{(CW-1){1'b0}}, 1'b1};
    localparam logic          HS_ACTIVE  = (HSYNC_POL != 0);
    localparam logic          VS_ACTIVE  = (VSYNC_POL != 0);

    logic          x_wrap;
    logic          y_wrap;
    logic [CW-1:0] x_next;
    logic [CW-1:0] y_next;
    logic          h_in_sync;
    logic          v_in_sync;
    logic          active_next;

    // Outputs are decoded from the next counter values so they line up with Xpixel/Ypixel.
    always_comb begin
        x_wrap      = (Xpixel == H_MAX);
        y_wrap      = (Ypixel == V_MAX);
        x_next      = x_wrap ? '0 : Xpixel + ONE;
        y_next      = Ypixel;
        if (x_wrap) begin
            y_next = y_wrap ? '0 : Ypixel + ONE;
        end
        h_in_sync   = (x_next >= HS_FIRST) && (x_next <= HS_LAST);
        v_in_sync   = (y_next >= VS_FIRST) && (y_next <= VS_LAST);
        active_next = (x_next < H_ACT) && (y_next < V_ACT);
    end

    always_ff @(posedge PixelClock or posedge Reset) begin
        if (Reset) begin
            Xpixel     <= H_MAX;
            Ypixel     <= V_MAX;
            Hsync      <= ~HS_ACTIVE;
            Vsync      <= ~VS_ACTIVE;
            displayON  <= 1'b0;
            LineStart  <= 1'b0;
            FrameStart <= 1'b0;
        end else begin
            // Pulses drop on every edge so a stall never stretches them.
            LineStart  <= 1'b0;
            FrameStart <= 1'b0;
            if (PixelEnable) begin
                Xpixel     <= x_next;
                Ypixel     <= y_next;
                Hsync      <= h_in_sync ? HS_ACTIVE : ~HS_ACTIVE;
                Vsync      <= v_in_sync ? VS_ACTIVE : ~VS_ACTIVE;
                displayON  <= active_next;
                LineStart  <= x_wrap;
                FrameStart <= x_wrap && y_wrap;
            end
        end
    end

`ifdef VGA_FRAME_COUNT_EN
    always_ff @(posedge PixelClock or posedge Reset) begin
        if (Reset) begin
            FrameCount <= 8'd0;
        end else if (PixelEnable && x_wrap && y_wrap) begin
            FrameCount <= FrameCount + 8'd1;
        end
    end
`endif

endmodule
